// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory issue scheduler.
package mem_sched_pkg;

  localparam int unsigned TAG_W       = 3;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SCHED_DEPTH = 4;

  // One buffered load/store; base/data hold a producer tag in [TAG_W-1:0] while not ready
  typedef struct packed {
    logic              valid;
    logic              issued;
    logic              is_store;
    logic [TAG_W-1:0]  id;
    logic              base_rdy;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] offset;
    logic              data_rdy;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Payload handed to the memory pipe
  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic [TAG_W-1:0]  id;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] store_data;
  } issue_t;

  // Pointer width for a power-of-two buffer depth
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Effective address of an entry
  function automatic logic [DATA_W-1:0] eff_addr(input entry_t e);
    return DATA_W'(e.base + e.offset);
  endfunction

endpackage

// File: rtl/mem_sched_picker.sv
// Oldest-eligible selector: priority encoder rotated so the head slot wins.
module mem_sched_picker
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = SCHED_DEPTH,
  parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0] elig,
  input  logic [PTR_W-1:0] head,
  output logic             gnt_valid_c,
  output logic [PTR_W-1:0] gnt_idx_c
);

  logic [PTR_W-1:0] idx_c;

  // Walk from youngest to oldest so the oldest eligible slot is the last one written
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    idx_c       = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      idx_c = head + PTR_W'(i);
      if (elig[idx_c]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = idx_c;
      end
    end
  end

endmodule

// File: rtl/mem_issue_scheduler.sv
// Load/store buffer with CDB operand capture and in-order-safe single issue.
// Optional: define MEM_SCHED_LOAD_BYPASS_EN to let loads pass older unissued
// stores whose address is known and different.
module mem_issue_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = SCHED_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic                   alloc_is_store,
  input  logic [TAG_W-1:0]       alloc_id,
  input  logic                   alloc_base_rdy,
  input  logic [DATA_W-1:0]      alloc_base,
  input  logic [DATA_W-1:0]      alloc_offset,
  input  logic                   alloc_data_rdy,
  input  logic [DATA_W-1:0]      alloc_data,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_value,
  output logic                   mem_valid_M,
  output logic                   mem_MemRead_M,
  output logic                   mem_MemWrite_M,
  output logic [TAG_W-1:0]       mem_id_M,
  output logic [DATA_W-1:0]      mem_srcA_M,
  output logic [DATA_W-1:0]      mem_srcB_M,
  output logic [DATA_W-1:0]      mem_store_data_M,
  output logic [ptr_w(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d, freed;
  logic             alloc_ready_q, alloc_ready_d;
  issue_t           iss_q, iss_d;

  logic [DEPTH-1:0] elig_c;
  logic             gnt_valid_c;
  logic [PTR_W-1:0] gnt_idx_c;
  logic             older_ok, free_run, do_alloc;
  logic [PTR_W-1:0] age_j, age_k, fidx;
  entry_t           new_ent;

  // Eligibility: operands ready and no older unissued op that must stay ahead
  always_comb begin
    elig_c   = '0;
    older_ok = 1'b0;
    age_j    = '0;
    age_k    = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      older_ok = ent_q[j].valid && !ent_q[j].issued && ent_q[j].base_rdy &&
                 (!ent_q[j].is_store || ent_q[j].data_rdy);
      age_j = PTR_W'(j) - head_q;
      for (int k = 0; k < int'(DEPTH); k++) begin
        age_k = PTR_W'(k) - head_q;
        if (ent_q[k].valid && !ent_q[k].issued && (age_k < age_j)) begin
          if (ent_q[j].is_store) begin
            older_ok = 1'b0;
          end else if (ent_q[k].is_store) begin
`ifdef MEM_SCHED_LOAD_BYPASS_EN
            if (!ent_q[k].base_rdy || (eff_addr(ent_q[k]) == eff_addr(ent_q[j])))
              older_ok = 1'b0;
`else
            older_ok = 1'b0;
`endif
          end
        end
      end
      elig_c[j] = older_ok;
    end
  end

  mem_sched_picker #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_picker (
    .elig        (elig_c),
    .head        (head_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Next state: CDB snoop, issue mark, head retire, tail alloc
  always_comb begin
    ent_d    = ent_q;
    head_d   = head_q;
    tail_d   = tail_q;
    iss_d    = '0;
    freed    = '0;
    free_run = 1'b1;
    fidx     = '0;
    new_ent  = '0;
    do_alloc = alloc_valid && alloc_ready_q;

    for (int j = 0; j < int'(DEPTH); j++) begin
      if (cdb_valid && ent_q[j].valid) begin
        if (!ent_q[j].base_rdy && (ent_q[j].base[TAG_W-1:0] == cdb_tag)) begin
          ent_d[j].base     = cdb_value;
          ent_d[j].base_rdy = 1'b1;
        end
        if (ent_q[j].is_store && !ent_q[j].data_rdy && (ent_q[j].data[TAG_W-1:0] == cdb_tag)) begin
          ent_d[j].data     = cdb_value;
          ent_d[j].data_rdy = 1'b1;
        end
      end
    end

    if (gnt_valid_c) begin
      ent_d[gnt_idx_c].issued = 1'b1;
      iss_d.valid      = 1'b1;
      iss_d.mem_read   = !ent_q[gnt_idx_c].is_store;
      iss_d.mem_write  = ent_q[gnt_idx_c].is_store;
      iss_d.id         = ent_q[gnt_idx_c].id;
      iss_d.src_a      = ent_q[gnt_idx_c].base;
      iss_d.src_b      = ent_q[gnt_idx_c].offset;
      iss_d.store_data = ent_q[gnt_idx_c].is_store ? ent_q[gnt_idx_c].data : '0;
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      fidx = head_q + PTR_W'(i);
      if (free_run && ent_d[fidx].valid && ent_d[fidx].issued) begin
        ent_d[fidx] = '0;
        freed       = freed + OCC_W'(1);
      end else begin
        free_run = 1'b0;
      end
    end
    head_d = head_q + PTR_W'(freed);

    if (do_alloc) begin
      new_ent.valid    = 1'b1;
      new_ent.is_store = alloc_is_store;
      new_ent.id       = alloc_id;
      new_ent.base_rdy = alloc_base_rdy;
      new_ent.base     = alloc_base;
      new_ent.offset   = alloc_offset;
      new_ent.data_rdy = alloc_data_rdy;
      new_ent.data     = alloc_data;
      if (cdb_valid && !alloc_base_rdy && (alloc_base[TAG_W-1:0] == cdb_tag)) begin
        new_ent.base     = cdb_value;
        new_ent.base_rdy = 1'b1;
      end
      if (cdb_valid && alloc_is_store && !alloc_data_rdy && (alloc_data[TAG_W-1:0] == cdb_tag)) begin
        new_ent.data     = cdb_value;
        new_ent.data_rdy = 1'b1;
      end
      ent_d[tail_q] = new_ent;
      tail_d        = tail_q + PTR_W'(1);
    end

    occ_d         = occ_q + OCC_W'(do_alloc) - freed;
    alloc_ready_d = occ_d < OCC_W'(DEPTH);
  end

  // State and issue registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      alloc_ready_q <= 1'b1;
      iss_q         <= '0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      alloc_ready_q <= alloc_ready_d;
      iss_q         <= iss_d;
    end
  end

  assign alloc_ready      = alloc_ready_q;
  assign occupancy        = occ_q;
  assign mem_valid_M      = iss_q.valid;
  assign mem_MemRead_M    = iss_q.mem_read;
  assign mem_MemWrite_M   = iss_q.mem_write;
  assign mem_id_M         = iss_q.id;
  assign mem_srcA_M       = iss_q.src_a;
  assign mem_srcB_M       = iss_q.src_b;
  assign mem_store_data_M = iss_q.store_data;

endmodule
